// File: rtl/axi_nport_arbiter.sv
// N-master AXI3 arbiter: independent read/write FSMs share one external master port.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module axi_nport_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          s_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_MASTERS*4-1:0]        s_arlen,
  input  logic [NUM_MASTERS*3-1:0]        s_arsize,
  output logic [NUM_MASTERS-1:0]          s_arready,
  output logic [NUM_MASTERS-1:0]          s_rvalid,
  input  logic [NUM_MASTERS-1:0]          s_rready,
  output logic [DATA_W-1:0]               s_rdata,
  output logic [1:0]                      s_rresp,
  output logic                            s_rlast,
  input  logic [NUM_MASTERS-1:0]          s_awvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_MASTERS*4-1:0]        s_awlen,
  input  logic [NUM_MASTERS*3-1:0]        s_awsize,
  output logic [NUM_MASTERS-1:0]          s_awready,
  input  logic [NUM_MASTERS-1:0]          s_wvalid,
  input  logic [NUM_MASTERS*DATA_W-1:0]   s_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] s_wstrb,
  input  logic [NUM_MASTERS-1:0]          s_wlast,
  output logic [NUM_MASTERS-1:0]          s_wready,
  output logic [NUM_MASTERS-1:0]          s_bvalid,
  input  logic [NUM_MASTERS-1:0]          s_bready,
  output logic [1:0]                      s_bresp,
  output logic [ID_W-1:0]                 m_arid,
  output logic [ADDR_W-1:0]               m_araddr,
  output logic [3:0]                      m_arlen,
  output logic [2:0]                      m_arsize,
  output logic [1:0]                      m_arburst,
  output logic [1:0]                      m_arlock,
  output logic [3:0]                      m_arcache,
  output logic [2:0]                      m_arprot,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [ID_W-1:0]                 m_rid,
  input  logic [DATA_W-1:0]               m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rlast,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [ID_W-1:0]                 m_awid,
  output logic [ADDR_W-1:0]               m_awaddr,
  output logic [3:0]                      m_awlen,
  output logic [2:0]                      m_awsize,
  output logic [1:0]                      m_awburst,
  output logic [1:0]                      m_awlock,
  output logic [3:0]                      m_awcache,
  output logic [2:0]                      m_awprot,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [ID_W-1:0]                 m_wid,
  output logic [DATA_W-1:0]               m_wdata,
  output logic [DATA_W/8-1:0]             m_wstrb,
  output logic                            m_wlast,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  input  logic [ID_W-1:0]                 m_bid,
  input  logic [1:0]                      m_bresp,
  input  logic                            m_bvalid,
  output logic                            m_bready
);
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t         rd_state_reg, rd_state_next;
  wr_state_t         wr_state_reg, wr_state_next;
  logic [GW-1:0]     ar_grant_reg, ar_grant_next, aw_grant_reg, aw_grant_next;
  logic [ADDR_W-1:0] ar_addr_reg, ar_addr_next, aw_addr_reg, aw_addr_next;
  logic [3:0]        ar_len_reg, ar_len_next, aw_len_reg, aw_len_next;
  logic [2:0]        ar_size_reg, ar_size_next, aw_size_reg, aw_size_next;
  logic [GW-1:0]     ar_win, aw_win, rd_ptr, wr_ptr;
  int                ar_win_i, aw_win_i, ar_g_i, aw_g_i;
  logic              rd_addr_ph, rd_data_ph, wr_addr_ph, wr_data_ph, wr_resp_ph;
  logic              unused_ids;

  // Ordered search from 'start', wrapping; fixed priority simply starts at 0.
  function automatic logic [GW-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [GW-1:0] start);
    logic [GW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(start) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

`ifdef AXI_ARB_RR_EN
  logic [GW-1:0] rd_ptr_reg, wr_ptr_reg;

  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
    return (int'(g) == NUM_MASTERS - 1) ? '0 : g + GW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (rd_state_reg == R_IDLE && |s_arvalid) rd_ptr_reg <= next_ptr(ar_win);
      if (wr_state_reg == W_IDLE && |s_awvalid) wr_ptr_reg <= next_ptr(aw_win);
    end
  end
  assign rd_ptr = rd_ptr_reg;
  assign wr_ptr = wr_ptr_reg;
`else
  assign rd_ptr = '0;
  assign wr_ptr = '0;
`endif

  assign ar_win   = pick(s_arvalid, rd_ptr);
  assign aw_win   = pick(s_awvalid, wr_ptr);
  assign ar_win_i = int'(ar_win);
  assign aw_win_i = int'(aw_win);
  assign ar_g_i   = int'(ar_grant_reg);
  assign aw_g_i   = int'(aw_grant_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      wr_state_reg <= W_IDLE;
      ar_grant_reg <= '0;
      aw_grant_reg <= '0;
      ar_addr_reg  <= '0;
      aw_addr_reg  <= '0;
      ar_len_reg   <= '0;
      aw_len_reg   <= '0;
      ar_size_reg  <= '0;
      aw_size_reg  <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      wr_state_reg <= wr_state_next;
      ar_grant_reg <= ar_grant_next;
      aw_grant_reg <= aw_grant_next;
      ar_addr_reg  <= ar_addr_next;
      aw_addr_reg  <= aw_addr_next;
      ar_len_reg   <= ar_len_next;
      aw_len_reg   <= aw_len_next;
      ar_size_reg  <= ar_size_next;
      aw_size_reg  <= aw_size_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    ar_grant_next = ar_grant_reg;
    ar_addr_next  = ar_addr_reg;
    ar_len_next   = ar_len_reg;
    ar_size_next  = ar_size_reg;
    case (rd_state_reg)
      R_IDLE: if (|s_arvalid) begin
        rd_state_next = R_ADDR;
        ar_grant_next = ar_win;
        ar_addr_next  = s_araddr[ar_win_i*ADDR_W +: ADDR_W];
        ar_len_next   = s_arlen[ar_win_i*4 +: 4];
        ar_size_next  = s_arsize[ar_win_i*3 +: 3];
      end
      R_ADDR: if (m_arready) rd_state_next = R_DATA;
      R_DATA: if (m_rvalid && m_rready && m_rlast) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_grant_next = aw_grant_reg;
    aw_addr_next  = aw_addr_reg;
    aw_len_next   = aw_len_reg;
    aw_size_next  = aw_size_reg;
    case (wr_state_reg)
      W_IDLE: if (|s_awvalid) begin
        wr_state_next = W_ADDR;
        aw_grant_next = aw_win;
        aw_addr_next  = s_awaddr[aw_win_i*ADDR_W +: ADDR_W];
        aw_len_next   = s_awlen[aw_win_i*4 +: 4];
        aw_size_next  = s_awsize[aw_win_i*3 +: 3];
      end
      W_ADDR: if (m_awready) wr_state_next = W_DATA;
      W_DATA: if (m_wvalid && m_wready && m_wlast) wr_state_next = W_RESP;
      W_RESP: if (m_bvalid && m_bready) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  assign rd_addr_ph = (rd_state_reg == R_ADDR);
  assign rd_data_ph = (rd_state_reg == R_DATA);
  assign wr_addr_ph = (wr_state_reg == W_ADDR);
  assign wr_data_ph = (wr_state_reg == W_DATA);
  assign wr_resp_ph = (wr_state_reg == W_RESP);

  // Address channels come straight from the captured request, so they stay stable.
  assign m_arvalid = rd_addr_ph;
  assign m_arid    = ID_W'(ar_grant_reg);
  assign m_araddr  = ar_addr_reg;
  assign m_arlen   = ar_len_reg;
  assign m_arsize  = ar_size_reg;
  assign m_arburst = 2'b01;
  assign m_arlock  = '0;
  assign m_arcache = '0;
  assign m_arprot  = '0;
  assign m_awvalid = wr_addr_ph;
  assign m_awid    = ID_W'(aw_grant_reg);
  assign m_awaddr  = aw_addr_reg;
  assign m_awlen   = aw_len_reg;
  assign m_awsize  = aw_size_reg;
  assign m_awburst = 2'b01;
  assign m_awlock  = '0;
  assign m_awcache = '0;
  assign m_awprot  = '0;

  assign m_rready = rd_data_ph & s_rready[ar_grant_reg];
  assign s_rdata  = rd_data_ph ? m_rdata : '0;
  assign s_rresp  = rd_data_ph ? m_rresp : '0;
  assign s_rlast  = rd_data_ph & m_rlast;

  assign m_wvalid = wr_data_ph & s_wvalid[aw_grant_reg];
  assign m_wlast  = wr_data_ph & s_wlast[aw_grant_reg];
  assign m_wdata  = wr_data_ph ? s_wdata[aw_g_i*DATA_W +: DATA_W] : '0;
  assign m_wstrb  = wr_data_ph ? s_wstrb[aw_g_i*SW +: SW] : '0;
  assign m_wid    = wr_data_ph ? ID_W'(aw_grant_reg) : '0;
  assign m_bready = wr_resp_ph & s_bready[aw_grant_reg];
  assign s_bresp  = wr_resp_ph ? m_bresp : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
      assign s_arready[gi] = rd_addr_ph & m_arready & (ar_g_i == gi);
      assign s_rvalid[gi]  = rd_data_ph & m_rvalid  & (ar_g_i == gi);
      assign s_awready[gi] = wr_addr_ph & m_awready & (aw_g_i == gi);
      assign s_wready[gi]  = wr_data_ph & m_wready  & (aw_g_i == gi);
      assign s_bvalid[gi]  = wr_resp_ph & m_bvalid  & (aw_g_i == gi);
    end
  endgenerate

  // Response IDs are redundant: only one transaction per direction is ever in flight.
  assign unused_ids = ^{m_rid, m_bid};
endmodule

// File: tb/tb_axi_nport_arbiter.sv
// Directed self-checking bench for axi_nport_arbiter (3 masters, 32-bit address/data).
module tb_axi_nport_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*32-1:0] s_araddr, s_awaddr, s_wdata;
  logic [N*4-1:0]  s_arlen, s_awlen, s_wstrb;
  logic [N*3-1:0]  s_arsize, s_awsize;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp, s_bresp;
  logic          s_rlast;
  logic [N-1:0]  s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [3:0]    m_arid, m_rid, m_awid, m_wid, m_bid, m_arlen, m_awlen, m_arcache, m_awcache, m_wstrb;
  logic [31:0]   m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [2:0]    m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]    m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
  logic          m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic          m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  axi_nport_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bresp(s_bresp),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          gid, exp_g;
  logic [31:0] addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = '0;
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_bready = '0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accepts the next AR request and returns len+1 beats; 'keep' masks s_arvalid after the handshake.
  task automatic serve_read(input logic [2:0] keep, input int len, input logic [31:0] dbase,
                            output int g, output logic [31:0] a);
    int waited = 0;
    int beats  = 0;
    #1;
    while (!m_arvalid && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check("ar_wait", waited < 20, 1);
    g = int'(m_arid);
    a = m_araddr;
    check("ar_len", m_arlen, len);
    m_arready = 1'b1;
    #1;
    check("ar_ready_hot", s_arready, 3'b001 << g);
    @(negedge clk);
    m_arready = 1'b0;
    s_arvalid = s_arvalid & keep;
    for (int b = 0; b <= len; b++) begin
      m_rvalid = 1'b1; m_rdata = dbase + b; m_rlast = (b == len);
      #1;
      check("r_route", s_rvalid, 3'b001 << g);
      check("r_data", s_rdata, dbase + b);
      if (s_rvalid[g] && m_rready) beats++;
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    check("r_beats", beats, len + 1);
    $display("read  grant=%0d addr=0x%08h beats=%0d", g, a, beats);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    apply_reset;
    #1;
    check("rst_s_ready", {s_arready, s_awready, s_wready}, 0);
    check("rst_s_valid", {s_rvalid, s_bvalid}, 0);
    check("rst_m_valid", {m_arvalid, m_awvalid, m_wvalid}, 0);
    check("rst_m_ready", {m_rready, m_bready}, 0);

    // Single read from master 1, len 3
    s_arvalid = 3'b010; s_araddr[32 +: 32] = 32'h1FC0_0000; s_arlen[4 +: 4] = 4'd3;
    s_arsize[3 +: 3] = 3'd2; s_rready = 3'b111;
    serve_read(3'b000, 3, 32'hA000_0000, gid, addr);
    check("t1_arid", gid, 1);
    check("t1_araddr", addr, 32'h1FC0_0000);
    m_rvalid = 1'b1;
    #1;
    check("t1_idle_after_last", {s_rvalid, m_rready, m_arvalid}, 0);
    m_rvalid = 1'b0;

    // Three masters requesting continuously for six bursts
    apply_reset;
    s_araddr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    s_rready = 3'b111; s_arvalid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      serve_read(3'b111, 0, 32'h100 * k, gid, addr);
`ifdef AXI_ARB_RR_EN
      exp_g = k % 3;
`else
      exp_g = 0;
`endif
      check("t2_grant", gid, exp_g);
      check("t2_addr", addr, 32'h1000 * (exp_g + 1));
    end
    s_arvalid = '0;

    // Master 2 write, len 1, with m_wready toggling and a late B response
    apply_reset;
    s_awvalid = 3'b100; s_awaddr[64 +: 32] = 32'h8000_0040; s_awlen[8 +: 4] = 4'd1;
    s_awsize[6 +: 3] = 3'd2; s_wvalid = 3'b100; s_wdata[64 +: 32] = 32'hDEAD_0000;
    s_wstrb[8 +: 4] = 4'hF; s_bready = 3'b100; m_awready = 1'b1;
    @(negedge clk); #1;
    check("t3_awvalid", {m_awvalid, m_awid}, {1'b1, 4'd2});
    check("t3_awaddr", {m_awaddr, m_awlen, m_awburst}, {32'h8000_0040, 4'd1, 2'b01});
    check("t3_awready_hot", s_awready, 3'b100);
    @(negedge clk);
    s_awvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    #1;
    check("t3_w0_stall", {m_wvalid, m_wlast, s_wready, m_wid}, {1'b1, 1'b0, 3'b000, 4'd2});
    @(negedge clk);
    m_wready = 1'b1;
    #1;
    check("t3_w0", {s_wready, m_wdata, m_wstrb}, {3'b100, 32'hDEAD_0000, 4'hF});
    @(negedge clk);
    s_wdata[64 +: 32] = 32'hBEEF_0001; s_wlast = 3'b100; m_wready = 1'b0;
    #1;
    check("t3_w1_stall", {m_wvalid, m_wlast, s_wready}, {1'b1, 1'b1, 3'b000});
    @(negedge clk);
    m_wready = 1'b1;
    #1;
    check("t3_w1", {s_wready, m_wlast, m_wdata}, {3'b100, 1'b1, 32'hBEEF_0001});
    @(negedge clk);
    m_wready = 1'b0; s_wvalid = '0; s_wlast = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_b_wait", {m_wvalid, s_bvalid, m_bready}, {1'b0, 3'b000, 1'b1});
      @(negedge clk);
    end
    m_bvalid = 1'b1; m_bresp = 2'b10;
    #1;
    check("t3_b", {s_bvalid, s_bresp}, {3'b100, 2'b10});
    @(negedge clk); #1;
    check("t3_b_done", {s_bvalid, m_bready}, 0);
    m_bvalid = 1'b0; m_bresp = '0;
    $display("write grant=2 addr=0x80000040 beats=2 bresp=2");

    // Concurrent read (master 0) and write (master 2)
    apply_reset;
    s_arvalid = 3'b001; s_araddr[0 +: 32] = 32'h0000_1000;
    s_awvalid = 3'b100; s_awaddr[64 +: 32] = 32'h0000_2000;
    s_wvalid = 3'b100; s_wdata[64 +: 32] = 32'h5555_AAAA; s_wlast = 3'b100;
    s_rready = 3'b001; s_bready = 3'b100; m_arready = 1'b1; m_awready = 1'b1;
    @(negedge clk); #1;
    check("t4_both_valid", {m_arvalid, m_awvalid}, 2'b11);
    check("t4_both_ready", {s_arready, s_awready}, {3'b001, 3'b100});
    check("t4_ids", {m_arid, m_awid}, {4'd0, 4'd2});
    @(negedge clk);
    s_arvalid = '0; s_awvalid = '0; m_arready = 1'b0; m_awready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h1234_5678; m_wready = 1'b1;
    #1;
    check("t4_r", {s_rvalid, s_rdata, s_rlast}, {3'b001, 32'h1234_5678, 1'b1});
    check("t4_w", {s_wready, m_wdata}, {3'b100, 32'h5555_AAAA});
    @(negedge clk);
    m_rlast = 1'b0; m_wready = 1'b0; s_wvalid = '0; s_wlast = '0; m_bvalid = 1'b1;
    #1;
    check("t4_b_rd_idle", {s_bvalid, s_rvalid, m_rready}, {3'b100, 3'b000, 1'b0});
    @(negedge clk);
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    $display("read  grant=0 + write grant=2 concurrent");

    // AR stall: request must stay stable even after the master changes its inputs
    apply_reset;
    s_arvalid = 3'b100; s_araddr[64 +: 32] = 32'hCAFE_0100; s_arlen[8 +: 4] = 4'd5;
    @(negedge clk);
    s_arvalid = '0; s_araddr[64 +: 32] = 32'h0BAD_0BAD; s_arlen[8 +: 4] = 4'd7;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t5_hold", {m_arvalid, m_arid, m_arlen, m_araddr, s_arready},
            {1'b1, 4'd2, 4'd5, 32'hCAFE_0100, 3'b000});
      @(negedge clk);
    end
    m_arready = 1'b1;
    #1;
    check("t5_ready", s_arready, 3'b100);
    @(negedge clk);
    m_arready = 1'b0;
    $display("read  grant=2 addr=0xcafe0100 stalled 5 cycles");

    // Reset during beat 2 of a len-7 read
    apply_reset;
    s_arvalid = 3'b010; s_araddr[32 +: 32] = 32'h1000_0000; s_arlen[4 +: 4] = 4'd7;
    s_rready = 3'b111; m_arready = 1'b1;
    @(negedge clk);
    s_arvalid = '0;
    @(negedge clk);
    m_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1'b1; m_rdata = b;
      #1;
      check("t6_beat", s_rvalid, 3'b010);
      @(negedge clk);
    end
    rst = 1'b1; m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    s_wvalid = 3'b111; s_bready = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_valids", {m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid}, 0);
    check("t6_readys", {s_arready, s_awready, s_wready, m_rready, m_bready}, 0);
    m_rvalid = 1'b0; m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    s_wvalid = '0; s_bready = '0;
    s_araddr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000}; s_arlen = '0;
    s_arvalid = 3'b111;
    serve_read(3'b000, 0, 32'h7700_0000, gid, addr);
    check("t6_regrant", gid, 0);
    check("t6_readdr", addr, 32'h0000_1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
